// File: rtl/period_accumulator_pkg.sv
// Shared frequency-meter constants: sample width, register-file depth and its
// index width.
package period_accumulator_pkg;
  localparam int PA_DATA_W    = 24;
  localparam int PA_N_SAMPLES = 4;
  localparam int PA_ADDR_W    = 2;
endpackage

// File: rtl/sample_regfile.sv
// Period-sample register file: one synchronous write port and one
// combinational read port.
module sample_regfile
  import period_accumulator_pkg::*;
#(
  parameter int DATA_W = PA_DATA_W,
  parameter int DEPTH  = PA_N_SAMPLES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [PA_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [PA_ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0]    rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end else begin
      mem_d[wr_addr] = mem_q[wr_addr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Reads the current register value, so a same-edge write is seen one cycle later.
  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/period_accumulator.sv
// Accumulates four period samples into sum / mean / max / min / spread and
// publishes them as registered results on done.
module period_accumulator
  import period_accumulator_pkg::*;
#(
  parameter int DATA_W    = PA_DATA_W,
  parameter int N_SAMPLES = PA_N_SAMPLES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [PA_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [PA_ADDR_W-1:0] address_r,
  input  logic                 load,
  input  logic                 done,
  output logic [DATA_W+1:0]    sum_out,
  output logic [DATA_W-1:0]    avg_out,
  output logic [DATA_W-1:0]    max_out,
  output logic [DATA_W-1:0]    min_out,
  output logic [DATA_W-1:0]    spread_out,
  output logic                 avg_valid
);

  logic [DATA_W-1:0] sample_s;
  logic [DATA_W+1:0] acc_q, acc_d;
  logic [DATA_W-1:0] max_q, max_d, min_q, min_d;
  logic [DATA_W+1:0] sum_q, sum_d;
  logic [DATA_W-1:0] avg_q, avg_d, maxo_q, maxo_d, mino_q, mino_d, spread_q, spread_d;
  logic              valid_q, valid_d;

  sample_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (N_SAMPLES)
  ) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (address_r),
    .rd_data (sample_s)
  );

  always_comb begin
    acc_d = acc_q;
    max_d = max_q;
    min_d = min_q;
    if (load) begin
      if (address_r == {PA_ADDR_W{1'b0}}) begin
        acc_d = {2'b00, sample_s};
        max_d = sample_s;
        min_d = sample_s;
      end else begin
        acc_d = acc_q + {2'b00, sample_s};
        max_d = (sample_s > max_q) ? sample_s : max_q;
        min_d = (sample_s < min_q) ? sample_s : min_q;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Results snapshot the pre-load running state, so load and done may coincide.
  always_comb begin
    sum_d    = sum_q;
    avg_d    = avg_q;
    maxo_d   = maxo_q;
    mino_d   = mino_q;
    spread_d = spread_q;
    valid_d  = done;
    if (done) begin
      sum_d    = acc_q;
      avg_d    = acc_q[DATA_W+1:2];
      maxo_d   = max_q;
      mino_d   = min_q;
      spread_d = max_q - min_q;
    end else begin
      sum_d    = sum_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      max_q    <= '0;
      min_q    <= '0;
      sum_q    <= '0;
      avg_q    <= '0;
      maxo_q   <= '0;
      mino_q   <= '0;
      spread_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      max_q    <= max_d;
      min_q    <= min_d;
      sum_q    <= sum_d;
      avg_q    <= avg_d;
      maxo_q   <= maxo_d;
      mino_q   <= mino_d;
      spread_q <= spread_d;
      valid_q  <= valid_d;
    end
  end

  assign sum_out    = sum_q;
  assign avg_out    = avg_q;
  assign max_out    = maxo_q;
  assign min_out    = mino_q;
  assign spread_out = spread_q;
  assign avg_valid  = valid_q;

endmodule

// File: doc/period_accumulator.md
PERIOD_ACCUMULATOR -- requirements
Module: period_accumulator

Interface
REQ-001 SHALL have parameter DATA_W, default 24: width of one period sample in reference-clock counts.
REQ-002 SHALL have parameter N_SAMPLES, default 4, fixed: number of sample registers (addresses 0..3).
REQ-003 SHALL have port clk, input, 1, single clock for all state.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port wr_en, input, 1, writes wr_data into the sample register at wr_addr at the clock edge.
REQ-006 SHALL have port wr_addr, input, 2, sample register write index.
REQ-007 SHALL have port wr_data, input, DATA_W, period sample from the capture stage.
REQ-008 SHALL have port address_r, input, 2, read index from the accumulator control FSM.
REQ-009 SHALL have port load, input, 1, accumulate the sample at address_r this cycle.
REQ-010 SHALL have port done, input, 1, sequence complete; publish results.
REQ-011 SHALL have port sum_out, output, DATA_W+2, registered sum of the 4 samples.
REQ-012 SHALL have port avg_out, output, DATA_W, registered mean, sum_out>>2, truncated.
REQ-013 SHALL have port max_out, output, DATA_W, largest sample in the sequence.
REQ-014 SHALL have port min_out, output, DATA_W, smallest sample in the sequence.
REQ-015 SHALL have port spread_out, output, DATA_W, max_out minus min_out.
REQ-016 SHALL have port avg_valid, output, 1, one-cycle pulse when the outputs update.

Function
REQ-017 SHALL read samples combinationally at address_r; a write at the same edge to the same address is not visible until the next cycle, so load captures the pre-write value.
REQ-018 SHALL, on load with address_r==0, replace the accumulator with the sample, and set running max and running min to the sample.
REQ-019 SHALL, on load with address_r!=0, add the zero-extended sample to the DATA_W+2-bit accumulator, and update running max and min by unsigned compare.
REQ-020 SHALL NOT overflow the accumulator: 4 x (2^DATA_W - 1) fits in DATA_W+2 bits.
REQ-021 SHALL, at a clock edge with done=1, latch sum_out, avg_out=acc[DATA_W+1:2], max_out, min_out and spread_out from the internal registers.
REQ-022 SHALL assert avg_valid for exactly the one cycle after the done edge; result outputs hold until the next done.
REQ-023 SHALL, if load and done coincide, latch the pre-update accumulator on done and still apply the load.
REQ-024 SHALL apply load with address_r!=0 when no address-0 load has occurred since reset, accumulating onto the reset values.
REQ-025 SHALL support back-to-back sequences, with done followed by the address-0 load one cycle later, without lost or stale data.

Reset
REQ-026 SHALL clear all sample registers, the accumulator and the running max/min to 0 asynchronously on reset_n low.
REQ-027 SHALL clear sum_out, avg_out, max_out, min_out, spread_out and avg_valid to 0 on reset_n low.
REQ-028 SHALL make no output change after reset is released mid-sequence until a later done edge.

Structure
REQ-029 SHALL take DATA_W default, N_SAMPLES and ADDR_W=2 from the shared frequency-meter package.
REQ-030 SHALL place the 4-entry register file in sub-module sample_regfile, with 1 write port and 1 asynchronous read port.
REQ-031 SHALL contain the accumulator, the max/min trackers and the output registers in period_accumulator itself.

Verification
REQ-032 SHALL cover: write 10,20,30,40 to addresses 0..3, then run the load/done sequence -> sum 100, avg 25, max 40, min 10, spread 30, avg_valid one cycle.
REQ-033 SHALL cover: all samples 0xFFFFFF -> sum 0x3FFFFFC, avg 0xFFFFFF, spread 0, no wrap.
REQ-034 SHALL cover: samples 7,7,7,8 -> sum 29, avg 7 (truncation), max 8, min 7.
REQ-035 SHALL cover: a write of 99 to address 2 in the same cycle as load at address 2 with old value 30 -> sum uses 30; the next sequence uses 99.
REQ-036 SHALL cover: reset_n pulsed low after the second load -> all outputs 0; a following full sequence gives correct results.
REQ-037 SHALL cover: two back-to-back sequences with samples 10,20,30,40 then 1,2,3,4 -> second result sum 10, avg 2, max 4, min 1.
